// File: rtl/fifo_to_axi4m_write_if.sv
// AXI4 write-channel bundle (AW/W/B) used by fifo_to_axi4m_write.
// The master modport is the burst writer; the slave modport is the memory side.
interface fifo_to_axi4m_write_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic [0:0]          awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/fifo_to_axi4m_write.sv
// Streams a kicked number of FWFT FIFO words to memory as AXI4 INCR bursts (<=64 beats).
// Define FIFO_TO_AXI4M_4K_BOUNDARY_EN to split bursts so none crosses a 4 KB page.
module fifo_to_axi4m_write #(
  parameter int C_M_AXI_ID_WIDTH   = 4,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          kick,
  output logic                          busy,
  input  logic [31:0]                   write_num,
  input  logic [31:0]                   write_addr,
  output logic                          error,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] buf_din,
  input  logic                          buf_empty,
  output logic                          buf_re,
  fifo_to_axi4m_write_if.master         m_axi
);

  localparam int BPB  = C_M_AXI_DATA_WIDTH / 8;
  localparam int SIZE = $clog2(BPB);

  typedef enum logic [2:0] {
    s_idle,
    s_kick,
    s_addrcalc,
    s_addrissue,
    s_data,
    s_respwait
  } state_t;

  state_t      state;
  logic [31:0] rem;
  logic [31:0] addr;
  logic [7:0]  beat_cnt;
  logic [7:0]  issue_cnt;
  logic [7:0]  resp_cnt;
  logic [6:0]  burst_len;
  logic        in_data;
  logic        w_hs;
  logic        b_hs;
  logic        resp_done;
  logic        unused_bid;

  assign m_axi.awid    = '0;
  assign m_axi.awsize  = 3'(SIZE);
  assign m_axi.awburst = 2'b01;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = 4'b0010;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.wstrb   = '1;

  // The FIFO is first-word-fall-through, so its head word goes straight onto W.
  assign in_data       = (state == s_data);
  assign m_axi.wdata   = buf_din;
  assign m_axi.wvalid  = in_data && !buf_empty;
  assign m_axi.wlast   = in_data && (beat_cnt == m_axi.awlen);
  assign w_hs          = m_axi.wvalid && m_axi.wready;
  assign buf_re        = w_hs;

  assign m_axi.bready  = busy;
  assign b_hs          = m_axi.bvalid && m_axi.bready;
  // Counting a response that lands this very cycle lets busy drop one cycle earlier.
  assign resp_done     = (resp_cnt + {7'b0, b_hs}) == issue_cnt;
  assign unused_bid    = ^m_axi.bid;

`ifdef FIFO_TO_AXI4M_4K_BOUNDARY_EN
  logic [12:0] page_beats;
  assign page_beats = (13'd4096 - {1'b0, addr[11:0]}) >> SIZE;
`endif

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    burst_len = (rem > 32'd64) ? 7'd64 : rem[6:0];
`ifdef FIFO_TO_AXI4M_4K_BOUNDARY_EN
    if (page_beats < {6'b0, burst_len}) burst_len = page_beats[6:0];
`endif
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= s_idle;
      busy          <= 1'b0;
      error         <= 1'b0;
      rem           <= '0;
      addr          <= '0;
      beat_cnt      <= '0;
      issue_cnt     <= '0;
      resp_cnt      <= '0;
      m_axi.awaddr  <= '0;
      m_axi.awlen   <= '0;
      m_axi.awvalid <= 1'b0;
    end else begin
      if (b_hs) begin
        resp_cnt <= resp_cnt + 8'd1;
        if (m_axi.bresp != 2'b00) error <= 1'b1;
      end

      unique case (state)
        s_idle: begin
          issue_cnt <= '0;
          resp_cnt  <= '0;
          if (kick) begin
            state <= s_kick;
            busy  <= 1'b1;
          end
        end

        s_kick: begin
          rem   <= write_num;
          addr  <= write_addr;
          error <= 1'b0;
          // A zero-length kick passes through s_respwait, which exits at once with no bursts issued.
          state <= (write_num == 32'd0) ? s_respwait : s_addrcalc;
        end

        s_addrcalc: begin
          m_axi.awaddr  <= addr[C_M_AXI_ADDR_WIDTH-1:0];
          m_axi.awlen   <= {1'b0, burst_len} - 8'd1;
          m_axi.awvalid <= 1'b1;
          rem           <= rem - 32'(burst_len);
          addr          <= addr + (32'(burst_len) << SIZE);
          issue_cnt     <= issue_cnt + 8'd1;
          state         <= s_addrissue;
        end

        s_addrissue: begin
          if (m_axi.awready) begin
            m_axi.awvalid <= 1'b0;
            beat_cnt      <= '0;
            state         <= s_data;
          end
        end

        s_data: begin
          if (w_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (m_axi.wlast) state <= (rem != 32'd0) ? s_addrcalc : s_respwait;
          end
        end

        s_respwait: begin
          if (resp_done) begin
            state <= s_idle;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= s_idle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_to_axi4m_write.sv
// Directed bench for fifo_to_axi4m_write: FWFT FIFO model, AXI write-slave model, protocol monitor.
// The 4 KB split case follows FIFO_TO_AXI4M_4K_BOUNDARY_EN.
module tb_fifo_to_axi4m_write;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        kick = 1'b0;
  logic        busy;
  logic        error;
  logic [31:0] write_num = '0;
  logic [31:0] write_addr = '0;
  logic [31:0] buf_din;
  logic        buf_empty;
  logic        buf_re;

  fifo_to_axi4m_write_if axi ();

  fifo_to_axi4m_write dut (
    .clk        (clk),
    .reset      (reset),
    .kick       (kick),
    .busy       (busy),
    .write_num  (write_num),
    .write_addr (write_addr),
    .error      (error),
    .buf_din    (buf_din),
    .buf_empty  (buf_empty),
    .buf_re     (buf_re),
    .m_axi      (axi)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // FWFT FIFO: word j always holds pat(j), so expected W data is known by position alone.
  logic [31:0] fifo_mem [0:1023];
  int          wr_ptr = 0;
  int          rd_ptr = 0;

  function automatic logic [31:0] pat(input int j);
    return 32'hA500_0000 + 32'(j * 3);
  endfunction

  assign buf_din   = fifo_mem[rd_ptr[9:0]];
  assign buf_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) if (buf_re) rd_ptr <= rd_ptr + 1;

  // Slave-side logs and protocol monitor.
  logic [31:0] aw_addr_log [$];
  logic [7:0]  aw_len_log  [$];
  logic [31:0] w_log       [$];
  int          bursts_done = 0;
  int          b_sent = 0;
  int          proto_viol = 0;
  logic        aw_pend = 1'b0;
  logic        w_pend = 1'b0;
  logic [31:0] aw_prev_addr;
  logic [7:0]  aw_prev_len;
  logic [31:0] w_prev_data;
  logic [1:0]  resp_table [0:63];
  bit          stall_en = 1'b0;

  assign axi.bid = '0;

  always @(posedge clk) begin
    if ((aw_pend && (!axi.awvalid || axi.awaddr !== aw_prev_addr || axi.awlen !== aw_prev_len)) ||
        (w_pend && (!axi.wvalid || axi.wdata !== w_prev_data)))
      proto_viol <= proto_viol + 1;
    aw_pend      <= axi.awvalid && !axi.awready;
    aw_prev_addr <= axi.awaddr;
    aw_prev_len  <= axi.awlen;
    w_pend       <= axi.wvalid && !axi.wready;
    w_prev_data  <= axi.wdata;
    if (axi.awvalid && axi.awready) begin
      aw_addr_log.push_back(axi.awaddr);
      aw_len_log.push_back(axi.awlen);
    end
    if (axi.wvalid && axi.wready) begin
      w_log.push_back(axi.wdata);
      if (axi.wlast) bursts_done <= bursts_done + 1;
    end
    if (axi.bvalid && axi.bready) b_sent <= b_sent + 1;
  end

  always @(negedge clk) begin
    if (stall_en) begin
      axi.awready = ($urandom_range(0, 3) != 0);
      axi.wready  = ($urandom_range(0, 3) != 0);
    end else begin
      axi.awready = 1'b1;
      axi.wready  = 1'b1;
    end
    if (b_sent < bursts_done && (!stall_en || $urandom_range(0, 1) == 1)) begin
      axi.bvalid = 1'b1;
      axi.bresp  = resp_table[b_sent];
    end else begin
      axi.bvalid = 1'b0;
      axi.bresp  = 2'b00;
    end
  end

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int n);
    for (int k = 0; k < n; k++) begin
      fifo_mem[wr_ptr[9:0]] = pat(wr_ptr);
      wr_ptr++;
    end
  endtask

  // Leaves the bench one cycle after the kick cycle (busy should already be high).
  task automatic do_kick(input logic [31:0] num, input logic [31:0] addr);
    write_num  = num;
    write_addr = addr;
    kick       = 1'b1;
    step();
    kick       = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    check(tag, busy, 1'b0);
  endtask

  task automatic check_data(input string tag, input int base, input int n);
    int bad = 0;
    for (int k = 0; k < n && base + k < w_log.size(); k++)
      if (w_log[base + k] !== pat(base + k)) bad++;
    check({tag, "_count"}, w_log.size() - base, n);
    check({tag, "_order"}, bad, 0);
  endtask

  int aw0, w0, r0, b0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) resp_table[i] = 2'b00;

    // Reset state and fixed AXI fields
    reset = 1'b1;
    repeat (3) step();
    check("rst_busy",    busy, 1'b0);
    check("rst_awvalid", axi.awvalid, 1'b0);
    check("rst_wvalid",  axi.wvalid, 1'b0);
    check("rst_wlast",   axi.wlast, 1'b0);
    check("rst_bready",  axi.bready, 1'b0);
    check("rst_buf_re",  buf_re, 1'b0);
    check("rst_error",   error, 1'b0);
    check("rst_awaddr",  axi.awaddr, 32'h0);
    check("rst_awlen",   axi.awlen, 8'h0);
    check("const_awsize",  axi.awsize, 3'd2);
    check("const_awburst", axi.awburst, 2'b01);
    check("const_awcache", axi.awcache, 4'b0010);
    check("const_awprot",  axi.awprot, 3'b000);
    check("const_awlock",  axi.awlock, 1'b0);
    check("const_awid",    axi.awid, 4'h0);
    check("const_wstrb",   axi.wstrb, 4'hF);
    reset = 1'b0;
    step();

    // Test 1: 4 words at 0x1000, exact cycle timing, kick while busy ignored
    aw0 = aw_addr_log.size(); w0 = w_log.size(); r0 = rd_ptr; b0 = b_sent;
    push(4);
    do_kick(32'd4, 32'h1000);
    check("t1_busy_t1", busy, 1'b1);
    check("t1_awvalid_t1", axi.awvalid, 1'b0);
    step();
    check("t1_awvalid_t2", axi.awvalid, 1'b0);
    step();
    check("t1_awvalid_t3", axi.awvalid, 1'b1);
    check("t1_awaddr", axi.awaddr, 32'h1000);
    check("t1_awlen", axi.awlen, 8'd3);
    step();
    check("t1_wvalid_first", axi.wvalid, 1'b1);
    check("t1_wlast_first", axi.wlast, 1'b0);
    check("t1_wdata_first", axi.wdata, pat(w0));
    check("t1_buf_re_first", buf_re, 1'b1);
    write_num = 32'd7;
    kick = 1'b1;
    step();
    kick = 1'b0;
    step();
    step();
    check("t1_wlast_4th", axi.wlast, 1'b1);
    step();
    check("t1_busy_respwait", busy, 1'b1);
    step();
    check("t1_busy_fall", busy, 1'b0);
    repeat (4) step();
    check("t1_busy_after_ignored_kick", busy, 1'b0);
    check("t1_aw_count", aw_addr_log.size() - aw0, 1);
    check_data("t1_data", w0, 4);
    check("t1_pops", rd_ptr - r0, 4);
    check("t1_bresp_count", b_sent - b0, 1);
    check("t1_error", error, 1'b0);

    // Test 2: 130 words at 0 -> 64/64/2 beat bursts
    aw0 = aw_addr_log.size(); w0 = w_log.size(); r0 = rd_ptr; b0 = b_sent;
    push(130);
    do_kick(32'd130, 32'h0);
    wait_idle(2000, "t2_timeout");
    check("t2_aw_count", aw_addr_log.size() - aw0, 3);
    check("t2_aw0_addr", aw_addr_log[aw0],     32'h000);
    check("t2_aw1_addr", aw_addr_log[aw0 + 1], 32'h100);
    check("t2_aw2_addr", aw_addr_log[aw0 + 2], 32'h200);
    check("t2_aw0_len",  aw_len_log[aw0],     8'd63);
    check("t2_aw1_len",  aw_len_log[aw0 + 1], 8'd63);
    check("t2_aw2_len",  aw_len_log[aw0 + 2], 8'd1);
    check_data("t2_data", w0, 130);
    check("t2_pops", rd_ptr - r0, 130);
    check("t2_bresp_count", b_sent - b0, 3);
    check("t2_error", error, 1'b0);

    // Test 3: FIFO runs dry mid-burst plus random AW/W/B stalls
    aw0 = aw_addr_log.size(); w0 = w_log.size(); r0 = rd_ptr; b0 = b_sent;
    stall_en = 1'b1;
    push(30);
    do_kick(32'd70, 32'h2000);
    begin
      int n = 0;
      while (rd_ptr != wr_ptr && n < 1000) begin
        step();
        n++;
      end
    end
    check("t3_drain", rd_ptr, wr_ptr);
    repeat (5) step();
    check("t3_bubble_wvalid", axi.wvalid, 1'b0);
    check("t3_bubble_busy", busy, 1'b1);
    push(40);
    wait_idle(3000, "t3_timeout");
    stall_en = 1'b0;
    check("t3_aw_count", aw_addr_log.size() - aw0, 2);
    check("t3_aw0_addr", aw_addr_log[aw0],     32'h2000);
    check("t3_aw1_addr", aw_addr_log[aw0 + 1], 32'h2100);
    check("t3_aw0_len",  aw_len_log[aw0],     8'd63);
    check("t3_aw1_len",  aw_len_log[aw0 + 1], 8'd5);
    check_data("t3_data", w0, 70);
    check("t3_pops", rd_ptr - r0, 70);
    check("t3_bresp_count", b_sent - b0, 2);
    check("t3_proto_hold", proto_viol, 0);
    check("t3_error", error, 1'b0);

    // Test 4: middle response of three is SLVERR
    aw0 = aw_addr_log.size(); w0 = w_log.size(); r0 = rd_ptr; b0 = b_sent;
    resp_table[b_sent + 1] = 2'b10;
    push(150);
    do_kick(32'd150, 32'h3000);
    wait_idle(2000, "t4_timeout");
    check("t4_aw_count", aw_addr_log.size() - aw0, 3);
    check("t4_aw2_addr", aw_addr_log[aw0 + 2], 32'h3200);
    check("t4_aw2_len",  aw_len_log[aw0 + 2], 8'd21);
    check_data("t4_data", w0, 150);
    check("t4_bresp_count", b_sent - b0, 3);
    check("t4_error_sticky", error, 1'b1);

    // Test 5: zero-length kick clears error, busy for two cycles, kick while busy ignored
    aw0 = aw_addr_log.size(); w0 = w_log.size();
    do_kick(32'd0, 32'h4000);
    check("t5_busy_c1", busy, 1'b1);
    check("t5_error_c1", error, 1'b1);
    kick = 1'b1;
    step();
    kick = 1'b0;
    check("t5_busy_c2", busy, 1'b1);
    check("t5_error_cleared", error, 1'b0);
    step();
    check("t5_busy_c3", busy, 1'b0);
    step();
    check("t5_busy_c4", busy, 1'b0);
    check("t5_aw_count", aw_addr_log.size() - aw0, 0);
    check("t5_w_count", w_log.size() - w0, 0);

    // Test 6: 8 words at 0x0FF0 (4 KB crossing)
    aw0 = aw_addr_log.size(); w0 = w_log.size(); b0 = b_sent;
    push(8);
    do_kick(32'd8, 32'h0FF0);
    wait_idle(500, "t6_timeout");
`ifdef FIFO_TO_AXI4M_4K_BOUNDARY_EN
    check("t6_aw_count", aw_addr_log.size() - aw0, 2);
    check("t6_aw0_addr", aw_addr_log[aw0],     32'h0FF0);
    check("t6_aw0_len",  aw_len_log[aw0],     8'd3);
    check("t6_aw1_addr", aw_addr_log[aw0 + 1], 32'h1000);
    check("t6_aw1_len",  aw_len_log[aw0 + 1], 8'd3);
    check("t6_bresp_count", b_sent - b0, 2);
`else
    check("t6_aw_count", aw_addr_log.size() - aw0, 1);
    check("t6_aw0_addr", aw_addr_log[aw0], 32'h0FF0);
    check("t6_aw0_len",  aw_len_log[aw0], 8'd7);
    check("t6_bresp_count", b_sent - b0, 1);
`endif
    check_data("t6_data", w0, 8);
    check("t6_error", error, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
